// File: rtl/da_shift_accumulator_if.sv
// -----------------------------------------------------------------------------
// da_shift_accumulator_if
//   Bundles the operand handshake, the coefficient-ROM port and the result
//   handshake of the bit-serial DA engine.
//
//   Signals
//     in_valid/in_ready         operand triple handshake
//     in_a/in_b/in_c   [DW]     signed operands A, B, C
//     rom_addr         [3]      {A bit, B bit, C bit} of the current bit slice
//     rom_cs                    ROM chip select (high only while walking bits)
//     rom_data         [CW]     signed Q2.14 ROM word, combinational to rom_addr
//     out_valid/out_ready       result handshake
//     out_data         [ACC_W]  signed result
//
//   Modports
//     slave  : the DA engine
//     master : the environment (sample buffer, ROM, consumer)
// -----------------------------------------------------------------------------
interface da_shift_accumulator_if #(
  parameter int DW    = 16,
  parameter int CW    = 16,
  parameter int ACC_W = DW + CW + 2
);
  logic             in_valid;
  logic             in_ready;
  logic [DW-1:0]    in_a;
  logic [DW-1:0]    in_b;
  logic [DW-1:0]    in_c;
  logic [2:0]       rom_addr;
  logic             rom_cs;
  logic [CW-1:0]    rom_data;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_data;

  modport slave (
    input  in_valid, in_a, in_b, in_c, rom_data, out_ready,
    output in_ready, rom_addr, rom_cs, out_valid, out_data
  );

  modport master (
    output in_valid, in_a, in_b, in_c, rom_data, out_ready,
    input  in_ready, rom_addr, rom_cs, out_valid, out_data
  );
endinterface

// File: rtl/da_shift_accumulator.sv
// -----------------------------------------------------------------------------
// da_shift_accumulator
//   Bit-serial distributed-arithmetic engine for one DCT output term.
//   A triple (A, B, C) is latched, then walked MSB-first over DW cycles. Each
//   cycle the current bit slice addresses the external partial-sum ROM and the
//   returned word is shift-accumulated. The sign-bit slice carries weight
//   -2^(DW-1), so its ROM word is subtracted instead of added.
//
//   Ports
//     clk    : rising-edge clock
//     rst_n  : asynchronous active-low reset (aborts any operation)
//     bus    : da_shift_accumulator_if.slave (operands, ROM port, result)
//
//   Optional build macro
//     DA_ROUND_EN : out_data becomes round((acc) / 2^FRAC) saturated to a
//                   signed DW-bit value and sign-extended to ACC_W. Without
//                   it, out_data is the full-precision accumulator.
// -----------------------------------------------------------------------------
module da_shift_accumulator #(
  parameter int DW    = 16,
  parameter int CW    = 16,
  parameter int ACC_W = DW + CW + 2,
  parameter int FRAC  = 14
) (
  input  logic                    clk,
  input  logic                    rst_n,
  da_shift_accumulator_if.slave   bus
);

  localparam int CNT_W = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(DW - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Round-half-up by 2^FRAC, then clamp into the signed DW-bit range. The
  // clamped value fits DW bits, so truncating back to ACC_W leaves the upper
  // bits as sign copies.
  function automatic logic [ACC_W-1:0] round_sat(input logic [ACC_W-1:0] acc);
    logic signed [ACC_W:0] sum;
    logic signed [ACC_W:0] shr;
    logic signed [ACC_W:0] maxv;
    logic signed [ACC_W:0] minv;
    logic signed [ACC_W:0] sat;
    maxv = {{(ACC_W-DW+2){1'b0}}, {(DW-1){1'b1}}};
    minv = {{(ACC_W-DW+2){1'b1}}, {(DW-1){1'b0}}};
    sum  = $signed({acc[ACC_W-1], acc}) + $signed((ACC_W+1)'(1) << (FRAC - 1));
    shr  = sum >>> FRAC;
    if (shr > maxv)      sat = maxv;
    else if (shr < minv) sat = minv;
    else                 sat = shr;
    return sat[ACC_W-1:0];
  endfunction

  state_t             r_state;
  state_t             w_state_nxt;
  logic [DW-1:0]      r_sa;
  logic [DW-1:0]      r_sb;
  logic [DW-1:0]      r_sc;
  logic [CNT_W-1:0]   r_bitcnt;
  logic [ACC_W-1:0]   r_acc;
  logic [ACC_W-1:0]   r_out_data;

  logic               w_accept;
  logic               w_first;
  logic               w_last;
  logic [ACC_W-1:0]   w_rom_ext;
  logic [ACC_W-1:0]   w_acc_nxt;
  logic [ACC_W-1:0]   w_out_nxt;

  logic               w_in_ready;
  logic               w_rom_cs;
  logic [2:0]         w_rom_addr;
  logic               w_out_valid;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_rom_cs    = 1'b0;
    w_rom_addr  = 3'b000;
    w_out_valid = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) w_state_nxt = RUN;
      end
      RUN: begin
        w_rom_cs   = 1'b1;
        w_rom_addr = {r_sa[DW-1], r_sb[DW-1], r_sc[DW-1]};
        if (w_last) w_state_nxt = DONE;
      end
      DONE: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  assign w_accept  = (r_state == IDLE) && bus.in_valid;
  assign w_first   = (r_bitcnt == CNT_TOP);
  assign w_last    = (r_bitcnt == '0);
  assign w_rom_ext = {{(ACC_W-CW){bus.rom_data[CW-1]}}, bus.rom_data};

  // Sign slice is the first one seen, so it seeds the accumulator negated;
  // every later slice doubles what is there and adds the new word.
  assign w_acc_nxt = w_first ? (ACC_W'(0) - w_rom_ext)
                             : ((r_acc << 1) + w_rom_ext);

`ifdef DA_ROUND_EN
  assign w_out_nxt = round_sat(w_acc_nxt);
`else
  assign w_out_nxt = w_acc_nxt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sa       <= '0;
      r_sb       <= '0;
      r_sc       <= '0;
      r_bitcnt   <= '0;
      r_acc      <= '0;
      r_out_data <= '0;
    end else if (w_accept) begin
      r_sa     <= bus.in_a;
      r_sb     <= bus.in_b;
      r_sc     <= bus.in_c;
      r_bitcnt <= CNT_TOP;
      r_acc    <= '0;
    end else if (r_state == RUN) begin
      r_sa     <= r_sa << 1;
      r_sb     <= r_sb << 1;
      r_sc     <= r_sc << 1;
      r_bitcnt <= r_bitcnt - 1'b1;
      r_acc    <= w_acc_nxt;
      if (w_last) r_out_data <= w_out_nxt;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.rom_cs    = w_rom_cs;
  assign bus.rom_addr  = w_rom_addr;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = r_out_data;

endmodule

// File: tb/tb_da_shift_accumulator.sv
module tb_da_shift_accumulator;
  localparam int DW    = 16;
  localparam int CW    = 16;
  localparam int ACC_W = DW + CW + 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  da_shift_accumulator_if #(.DW(DW), .CW(CW), .ACC_W(ACC_W)) bus ();

  da_shift_accumulator #(.DW(DW), .CW(CW), .ACC_W(ACC_W), .FRAC(14)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Coefficient ROM model (Q2.14 partial sums).
  always_comb begin
    case (bus.rom_addr)
      3'b000:  bus.rom_data = 16'(0);
      3'b001:  bus.rom_data = 16'(-6270);
      3'b010:  bus.rom_data = 16'(15137);
      3'b011:  bus.rom_data = 16'(8867);
      3'b100:  bus.rom_data = 16'(-15137);
      3'b101:  bus.rom_data = 16'(-21407);
      3'b110:  bus.rom_data = 16'(0);
      default: bus.rom_data = 16'(-6270);
    endcase
  end

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] c;
    longint      full;  // hand-computed full-precision result
  } vec_t;

  vec_t vecs [11];
  int checks = 0;
  int errors = 0;

  function automatic longint expv(input longint full);
`ifdef DA_ROUND_EN
    longint v;
    v = (full + 64'sd8192) >>> 14;
    if (v > 32767)  v = 32767;
    if (v < -32768) v = -32768;
    return v;
`else
    return full;
`endif
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic longint odata();
    return longint'($signed(bus.out_data));
  endfunction

  // Issues one triple and returns once out_valid is seen (or the budget ends).
  // lat counts clock edges from the accepting edge through the one that
  // raises out_valid.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] c, output longint res,
                        output int lat, output int cs_cnt,
                        output logic [2:0] aor, output logic [2:0] aand);
    int n;
    n = 0; lat = 0; cs_cnt = 0; aor = 3'b000; aand = 3'b111; res = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    bus.in_a = a; bus.in_b = b; bus.in_c = c; bus.in_valid = 1'b1;
    @(posedge clk);
    lat = 1;
    #1 bus.in_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.out_valid) break;
      if (bus.rom_cs) begin
        cs_cnt++;
        aor  = aor  | bus.rom_addr;
        aand = aand & bus.rom_addr;
      end
      @(posedge clk);
      lat++;
    end
    res = odata();
  endtask

  task automatic ack();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    @(negedge clk);
    chk("ack_out_valid_drop", longint'(bus.out_valid), 0);
    chk("ack_in_ready", longint'(bus.in_ready), 1);
  endtask

  initial begin
    longint     res;
    longint     held;
    int         lat;
    int         cs_cnt;
    logic [2:0] aor;
    logic [2:0] aand;

    // A*(-15137) + B*15137 + C*(-6270), operands signed 16-bit.
    vecs[0]  = '{16'h0000, 16'h0000, 16'h0000, 0};
    vecs[1]  = '{16'h0000, 16'h0000, 16'h0001, -6270};
    vecs[2]  = '{16'h0000, 16'h0001, 16'h0000, 15137};
    vecs[3]  = '{16'h0000, 16'h0000, 16'hFFFF, 6270};
    vecs[4]  = '{16'h0001, 16'h0000, 16'h0001, -21407};
    vecs[5]  = '{16'h0000, 16'h0001, 16'h0001, 8867};
    vecs[6]  = '{16'h8000, 16'h0000, 16'h0000, 496009216};
    vecs[7]  = '{16'h7FFF, 16'h0000, 16'h0000, -495994079};
    vecs[8]  = '{16'h0000, 16'h7FFF, 16'h8000, 701449439};
    vecs[9]  = '{16'h0002, 16'h0003, 16'hFFFC, 40217};
    vecs[10] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 6270};

    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.in_a = '0; bus.in_b = '0; bus.in_c = '0;

    #3;
    chk("rst_in_ready",  longint'(bus.in_ready), 1);
    chk("rst_out_valid", longint'(bus.out_valid), 0);
    chk("rst_rom_cs",    longint'(bus.rom_cs), 0);
    chk("rst_rom_addr",  longint'(bus.rom_addr), 0);
    chk("rst_out_data",  odata(), 0);
    #9 rst_n = 1'b1;
    @(negedge clk);

    // Table-driven directed vectors.
    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].c, res, lat, cs_cnt, aor, aand);
      chk($sformatf("vec%0d_result", i), res, expv(vecs[i].full));
      chk($sformatf("vec%0d_latency", i), longint'(lat), DW + 1);
      chk($sformatf("vec%0d_rom_cs_cycles", i), longint'(cs_cnt), DW);
      if (i == 3) begin
        chk("vec3_addr_or",  longint'(aor), 1);
        chk("vec3_addr_and", longint'(aand), 1);
      end
      ack();
    end

    // Back-pressure: result held, in_ready low, stray triple ignored.
    run_op(16'h0001, 16'h0000, 16'h0001, res, lat, cs_cnt, aor, aand);
    chk("bp_result", res, expv(-21407));
    held = res;
    for (int k = 0; k < 10; k++) begin
      if (k == 3) begin
        bus.in_a = 16'h0000; bus.in_b = 16'h0001; bus.in_c = 16'h0000;
        bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
      chk($sformatf("bp_out_valid_%0d", k), longint'(bus.out_valid), 1);
      chk($sformatf("bp_out_data_%0d", k), odata(), held);
      chk($sformatf("bp_in_ready_%0d", k), longint'(bus.in_ready), 0);
    end
    bus.in_valid = 1'b0;
    ack();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("bp_no_queued_cs_%0d", k), longint'(bus.rom_cs), 0);
      chk($sformatf("bp_no_queued_valid_%0d", k), longint'(bus.out_valid), 0);
    end

    // Reset mid-RUN aborts; next triple runs normally.
    @(negedge clk);
    bus.in_a = 16'h0001; bus.in_b = 16'h0001; bus.in_c = 16'h0001;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("mid_run_rom_cs", longint'(bus.rom_cs), 1);
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready",  longint'(bus.in_ready), 1);
    chk("abort_out_valid", longint'(bus.out_valid), 0);
    chk("abort_rom_cs",    longint'(bus.rom_cs), 0);
    chk("abort_rom_addr",  longint'(bus.rom_addr), 0);
    chk("abort_out_data",  odata(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(16'h0000, 16'h0001, 16'h0001, res, lat, cs_cnt, aor, aand);
    chk("post_reset_result", res, expv(8867));
    chk("post_reset_latency", longint'(lat), DW + 1);
    ack();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/da_shift_accumulator.md
Name: da_shift_accumulator

Overview:
- Bit-serial distributed-arithmetic (DA) engine for the DCT datapath in System 2 (DCT+RLE).
- Accepts three signed samples (operands A, B, C) and walks their bits MSB-first. Each cycle it drives a 3-bit address into the downstream-facing combinational coefficient ROM (Q2.14 partial-sum table), reads the ROM word in the same cycle, and shift-accumulates it into one DCT output term.
- Sits directly between the sample buffer and a ROM of that family. Its result feeds the quantiser/RLE stage.

Parameters:
- DW, 16, sample width in bits; also the number of bit-serial cycles per result.
- CW, 16, ROM word width, signed Q2.14.
- ACC_W, DW+CW+2, accumulator and full-precision output width.
- FRAC, 14, fractional bits in a ROM word; used only by the optional rounding feature.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand triple valid
- in_ready  out  1  block can accept a triple
- in_a  in  DW  signed operand A; drives rom_addr[2]
- in_b  in  DW  signed operand B; drives rom_addr[1]
- in_c  in  DW  signed operand C; drives rom_addr[0]
- rom_addr  out  3  ROM address = {bit j of A, bit j of B, bit j of C}
- rom_cs  out  1  ROM chip select
- rom_data  in  CW  signed ROM word, combinational response to rom_addr
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_data  out  ACC_W  signed result

Behaviour:
- Reset is asynchronous, active-low. All outputs reset as follows:
  - state=IDLE, in_ready=1, out_valid=0, rom_cs=0, rom_addr=0, out_data=0.
  - Accumulator, operand shift registers and bit counter are cleared.
- States:
  - IDLE: in_ready=1. When in_valid=1, latch in_a/in_b/in_c, set bitcnt=DW-1, clear acc, go to RUN.
  - RUN: lasts DW cycles. rom_cs=1; rom_addr = MSBs of the three shift registers.
    - First RUN cycle (sign bit, bitcnt=DW-1): acc <= -sext(rom_data).
    - Remaining cycles: acc <= (acc<<1) + sext(rom_data).
    - Shift registers shift left 1 each cycle; bitcnt decrements.
    - After the bitcnt=0 cycle: out_data <= final acc, out_valid=1, go to DONE.
  - DONE: rom_cs=0, rom_addr=0, out_data held stable. On out_ready=1: out_valid drops the next cycle, go to IDLE.
- in_ready is 1 only in IDLE. in_valid is ignored in RUN and DONE; no triple is lost or queued.
- Latency: accept at edge 0; out_valid=1 after edge DW+1 (17 cycles for DW=16). Throughput is one result per DW+2 cycles minimum.
- Arithmetic is two's complement and sign-extended to ACC_W. Accumulation never overflows for |rom_data| ≤ 2^(CW-1); no saturation is applied in the base build.
- rom_cs=0 whenever not in RUN. rom_data is ignored outside RUN.
- Reset asserted mid-RUN or in DONE aborts the operation immediately; no partial result is emitted.
- out_valid=1 with out_ready=0 holds indefinitely with out_data unchanged.
- Operand values −2^(DW-1) and 2^(DW-1)−1 are handled exactly.

Optional Feature:
- Macro: DA_ROUND_EN.
- When defined:
  - out_data = sign-extension of a DW-bit value, computed as (acc + 2^(FRAC-1)) >>> FRAC.
  - The value is saturated to [−2^(DW-1), 2^(DW-1)−1].
  - The upper ACC_W−DW bits are sign copies.
  - Rounding/saturation is registered in the RUN→DONE transition, so latency is unchanged.
- When undefined: out_data is the full-precision ACC_W accumulator.

Test Plan:
- The bench ROM model returns 000→0, 001→−6270, 010→15137, 011→8867, 100→−15137, 101→−21407, 110→0, 111→−6270.
- Scenario 1: A=B=C=0 → out_data=0 after 17 cycles; rom_cs high for exactly 16 cycles.
- Scenario 2: A=0, B=0, C=1 → out_data=−6270. A=0, B=1, C=0 → out_data=15137.
- Scenario 3: A=0, B=0, C=−1 (0xFFFF) → every cycle rom_addr=001; out_data=+6270 (sign-bit subtraction check).
- Scenario 4: A=1, B=0, C=1 → out_data=−21407. Hold out_ready=0 for 10 cycles → out_valid and out_data stable, in_ready=0, a second in_valid pulse is ignored.
- Scenario 5: assert rst_n=0 at RUN cycle 8 → all outputs return to reset values immediately; the next triple (0,1,1) yields 8867.
- Scenario 6: with DA_ROUND_EN and A=0, B=1, C=1 → out_data=1, since (8867+8192)>>>14 = 1.
